// File: rtl/adder_pkg.sv
// Shared definitions for the byte-serial adder datapath and its sequencer.
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } seq_state_t;

    // Byte index counter width; a single-byte word still needs one bit.
    function automatic int idx_width(input int num_bytes);
        return (num_bytes > 1) ? $clog2(num_bytes) : 1;
    endfunction

endpackage

// File: rtl/multibyte_add_sequencer.sv
// Feeds a registered 8-bit adder one byte at a time (LSB first), chaining the
// carry, and assembles the full-width sum, carry-out and signed overflow.
module multibyte_add_sequencer
    import adder_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0]   op_a,
    input  logic [BYTE_W*NUM_BYTES-1:0]   op_b,
    input  logic                          op_cin,
    output logic [BYTE_W-1:0]             add_a,
    output logic [BYTE_W-1:0]             add_b,
    output logic                          add_cin,
    input  logic [BYTE_W-1:0]             add_sum,
    input  logic                          add_cout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BYTE_W*NUM_BYTES-1:0]   result,
    output logic                          result_cout,
    output logic                          result_ovf
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = idx_width(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    seq_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic             carry;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;

    assign next_idx = idx + 1'b1;

    // carry is only non-zero while a byte is being issued, so it drives the
    // adder carry-in directly from a flop.
    assign add_cin = carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result      <= '0;
            result_cout <= 1'b0;
            result_ovf  <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q         <= op_a;
                        b_q         <= op_b;
                        idx         <= '0;
                        carry       <= op_cin;
                        result      <= '0;
                        result_cout <= 1'b0;
                        result_ovf  <= 1'b0;
                        add_a       <= op_a[BYTE_W-1:0];
                        add_b       <= op_b[BYTE_W-1:0];
                        in_ready    <= 1'b0;
                        state       <= ISSUE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                ISSUE: begin
                    // The adder has sampled this byte; park its inputs at zero.
                    add_a <= '0;
                    add_b <= '0;
                    carry <= 1'b0;
                    state <= WAIT;
                end

                WAIT: begin
                    result[BYTE_W*idx +: BYTE_W] <= add_sum;
                    if (idx != LAST_IDX) begin
                        idx   <= next_idx;
                        carry <= add_cout;
                        add_a <= a_q[BYTE_W*next_idx +: BYTE_W];
                        add_b <= b_q[BYTE_W*next_idx +: BYTE_W];
                        state <= ISSUE;
                    end else begin
                        result_cout <= add_cout;
                        result_ovf  <= (a_q[W-1] == b_q[W-1]) && (add_sum[BYTE_W-1] != a_q[W-1]);
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed and random bench for multibyte_add_sequencer with a registered adder model.
module tb_multibyte_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_cin;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          result_cout;
    logic          result_ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_e;

    multibyte_add_sequencer #(.NUM_BYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_cout(result_cout), .result_ovf(result_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered 8-bit adder: result valid the cycle after its inputs are driven.
    always @(posedge clk) begin
        if (rst) begin
            add_sum  <= '0;
            add_cout <= 1'b0;
        end else begin
            {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {cout, ovf, sum}.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin);
        logic [W:0] s;
        logic       ovf;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {s[W], ovf, s[W-1:0]};
    endfunction

    // Carry entering byte k of a+b+cin.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input int k);
        logic [63:0] m;
        logic [63:0] s;
        m = (64'd1 << (8 * k)) - 64'd1;
        s = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
        return s[8 * k];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", {32'd0, result}, {32'd0, mon_e[W-1:0]});
                chk("result_ovf", {63'd0, result_ovf}, {63'd0, mon_e[W]});
                chk("result_cout", {63'd0, result_cout}, {63'd0, mon_e[W+1]});
            end
        end
    end

    // Offers one operand pair and returns just after the handshake edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit push, output int hs);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        if (push) exp_q.push_back(ref_model(a, b, cin));
        hs = cyc;
        step();
        in_valid = 1'b0;
    endtask

    // Checks every byte issue and the latency to out_valid; stops at first out_valid cycle.
    task automatic wait_done(input int hs, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        int k;
        int bi;
        forever begin
            k = cyc - hs;
            if (out_valid) begin
                chk("latency", 64'(k), 64'(2 * NB + 1));
                break;
            end
            if (k > 40) begin
                chk("out_valid_timeout", 64'd0, 64'd1);
                break;
            end
            if ((k % 2) == 1 && k <= 2 * NB - 1) begin
                bi = (k - 1) / 2;
                chk("add_a", {56'd0, add_a}, {56'd0, a[8*bi +: 8]});
                chk("add_b", {56'd0, add_b}, {56'd0, b[8*bi +: 8]});
                chk("add_cin", {63'd0, add_cin}, {63'd0, carry_into(a, b, cin, bi)});
            end
            step();
        end
    endtask

    task automatic op_full(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int hs;
        send(a, b, cin, 1'b1, hs);
        wait_done(hs, a, b, cin);
        step();
        chk("out_valid_one_cycle", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after_done", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int          hs;
        int          prev_hs;
        int          n;
        logic [W+1:0] e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic        rc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        repeat (3) step();

        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_flags", {62'd0, result_cout, result_ovf}, 64'd0);
        chk("reset_adder_ports", {47'd0, add_a, add_b, add_cin}, 64'd0);
        rst = 1'b0;
        step();

        // Directed arithmetic cases
        op_full(32'h0000_00FF, 32'h0000_0001, 1'b0);
        op_full(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        op_full(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        op_full(32'h8000_0000, 32'h8000_0000, 1'b0);

        // Backpressure: result held, in_ready low, in_valid ignored
        out_ready = 1'b0;
        ra = 32'h0F0F_F0F0;
        rb = 32'hF1F1_1F1F;
        send(ra, rb, 1'b1, 1'b1, hs);
        wait_done(hs, ra, rb, 1'b1);
        e = ref_model(ra, rb, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_result_stable", {30'd0, result_cout, result_ovf, result}, {30'd0, e});
            in_valid = i[0];
            op_a     = $urandom();
            op_b     = $urandom();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);

        // Reset in cycle 4 of an operation aborts it
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, hs);
        while (cyc < hs + 4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_flags", {62'd0, result_cout, result_ovf}, 64'd0);
        chk("abort_adder_ports", {47'd0, add_a, add_b, add_cin}, 64'd0);
        step();
        chk("abort_idle_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
        op_full(32'h1234_5678, 32'h1111_1111, 1'b0);

        // Back-to-back random traffic with in_valid held high
        in_valid = 1'b1;
        prev_hs  = 0;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!in_ready && n < 30) begin
                op_a   = $urandom();
                op_b   = $urandom();
                op_cin = 1'($urandom_range(0, 1));
                step();
                n++;
            end
            if (n >= 30) begin
                chk("b2b_in_ready_timeout", 64'd0, 64'd1);
                break;
            end
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            op_a   = ra;
            op_b   = rb;
            op_cin = rc;
            exp_q.push_back(ref_model(ra, rb, rc));
            hs = cyc;
            if (i > 0) chk("b2b_interval", 64'(hs - prev_hs), 64'(2 * NB + 2));
            prev_hs = hs;
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
